// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the result-beat record used by execute units.
package alu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int TAGW_DEF = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef struct packed {
        logic [XLEN_DEF-1:0] result;
        logic                zero;
        logic [TAGW_DEF-1:0] tag;
    } alu_beat_t;

endpackage

// File: rtl/alu_fn_core.sv
// Purely combinational RV32I-style ALU function (fn, op1, op2) -> result.
module alu_fn_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      fn,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = op2[SHW-1:0];

    always_comb begin
        result = '0;
        case (fn)
            ALU_ADD:  result = op1 + op2;
            ALU_SUB:  result = op1 - op2;
            ALU_SLL:  result = op1 << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            ALU_XOR:  result = op1 ^ op2;
            ALU_SRL:  result = op1 >> shamt;
            ALU_SRA:  result = $signed(op1) >>> shamt;
            ALU_OR:   result = op1 | op2;
            ALU_AND:  result = op1 & op2;
            // Unused codes still complete as a beat carrying zero.
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_pipe.sv
// Elastic ALU execute stage: compute into slice 0, then DEPTH-1 carry slices to the output.
// Optional macro ALU_PERF_CNT_EN adds saturating transfer/stall counters (perf_ops, perf_stall).
module alu_exec_pipe
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1,
    parameter int TAGW  = 5
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_fn,
    input  logic [XLEN-1:0] in_op1,
    input  logic [XLEN-1:0] in_op2,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic [TAGW-1:0] out_tag
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_ops,
    output logic [31:0]     perf_stall
`endif
);

    // Handshake: a beat moves across a boundary only in a cycle where the sender's valid
    // and the receiver's ready are both high; a presented output beat is held unchanged
    // until it transfers, and ready never depends on flush.

    logic [XLEN-1:0] fn_result;

    alu_fn_core #(.XLEN(XLEN)) u_core (
        .fn     (in_fn),
        .op1    (in_op1),
        .op2    (in_op2),
        .result (fn_result)
    );

    logic            s_valid  [DEPTH];
    logic [XLEN-1:0] s_result [DEPTH];
    logic            s_zero   [DEPTH];
    logic [TAGW-1:0] s_tag    [DEPTH];
    logic            adv      [DEPTH];

    // Ready chain runs from the output back to slice 0 so a full pipe streams without bubbles.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) adv[k] = 1'b0;
        adv[DEPTH-1] = !s_valid[DEPTH-1] || out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) adv[k] = !s_valid[k] || adv[k+1];
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        logic            src_valid;
        logic [XLEN-1:0] src_result;
        logic            src_zero;
        logic [TAGW-1:0] src_tag;

        if (k == 0) begin : g_head
            assign src_valid  = in_valid;
            assign src_result = fn_result;
            assign src_zero   = (fn_result == '0);
            assign src_tag    = in_tag;
        end else begin : g_body
            assign src_valid  = s_valid[k-1];
            assign src_result = s_result[k-1];
            assign src_zero   = s_zero[k-1];
            assign src_tag    = s_tag[k-1];
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                s_valid[k]  <= 1'b0;
                s_result[k] <= '0;
                s_zero[k]   <= 1'b1;
                s_tag[k]    <= '0;
            end else if (flush) begin
                s_valid[k]  <= 1'b0;
            end else if (adv[k]) begin
                s_valid[k] <= src_valid;
                // Payload only moves with a real beat, so an emptied slice keeps stable data.
                if (src_valid) begin
                    s_result[k] <= src_result;
                    s_zero[k]   <= src_zero;
                    s_tag[k]    <= src_tag;
                end
            end
        end
    end

    assign in_ready   = adv[0];
    assign out_valid  = s_valid[DEPTH-1];
    assign out_result = s_result[DEPTH-1];
    assign out_zero   = s_zero[DEPTH-1];
    assign out_tag    = s_tag[DEPTH-1];

`ifdef ALU_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready && (perf_ops != 32'hFFFF_FFFF))
                perf_ops <= perf_ops + 32'd1;
            if (out_valid && !out_ready && (perf_stall != 32'hFFFF_FFFF))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Scoreboard bench for alu_exec_pipe (DEPTH=3): directed, backpressure, flush, reset and random traffic.
module tb_alu_exec_pipe;

    localparam int XLEN  = 32;
    localparam int TAGW  = 5;
    localparam int DEPTH = 3;
    localparam int W     = XLEN + 1 + TAGW;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      in_fn = '0;
    logic [XLEN-1:0] in_op1 = '0;
    logic [XLEN-1:0] in_op2 = '0;
    logic [TAGW-1:0] in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic [TAGW-1:0] out_tag;
`ifdef ALU_PERF_CNT_EN
    logic [31:0]     perf_ops;
    logic [31:0]     perf_stall;
`endif

    alu_exec_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fn      (in_fn),
        .in_op1     (in_op1),
        .in_op2     (in_op2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_tag    (out_tag)
`ifdef ALU_PERF_CNT_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
`endif
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic         accepted = 1'b0;
    logic         hold_v   = 1'b0;
    logic [W-1:0] hold_d   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference ALU written from the operation definitions.
    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] fn, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        int unsigned sh;
        logic [XLEN-1:0] ones;
        sh   = b % XLEN;
        ones = '1;
        case (fn)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << sh;
            4'b0010: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return (a >> sh) | (a[XLEN-1] ? ~(ones >> sh) : '0);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] expect_beat(input logic [3:0] fn, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b, input logic [TAGW-1:0] t);
        logic [XLEN-1:0] r;
        r = ref_alu(fn, a, b);
        return {r, (r == '0), t};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        logic [W-1:0] e;
        if (!RST) begin
            if (hold_v) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", {out_result, out_zero, out_tag}, hold_d);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_beat");
                end else begin
                    e = exp_q.pop_front();
                    check("result_beat", {out_result, out_zero, out_tag}, e);
                end
            end
        end
        hold_v = out_valid && !out_ready && !RST && !flush;
        hold_d = {out_result, out_zero, out_tag};
    end

    // ---------------- driver tasks ----------------
    // One cycle: inputs already set; checks ready against occupancy, records acceptance.
    task automatic step();
        #1;
        if (!RST) check("in_ready", in_ready, out_ready || (exp_q.size() < DEPTH));
        @(negedge CLK);
        accepted = in_valid && in_ready && !flush && !RST;
        if (accepted) exp_q.push_back(expect_beat(in_fn, in_op1, in_op2, in_tag));
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [3:0] fn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAGW-1:0] t);
        in_fn  = fn;
        in_op1 = a;
        in_op2 = b;
        in_tag = t;
    endtask

    function automatic logic [XLEN-1:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_beat();
        load(4'($urandom_range(0, 15)), pick_op(), pick_op(), 5'($urandom_range(0, 31)));
    endtask

    task automatic send(input logic [3:0] fn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAGW-1:0] t);
        load(fn, a, b, t);
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (accepted) break;
        end
        if (!accepted) timeout("send");
        in_valid = 1'b0;
    endtask

    task automatic issue_and_check(input string name, input logic [3:0] fn, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic [TAGW-1:0] t,
                                   input logic [XLEN-1:0] exp_r);
        int n;
        out_ready = 1'b1;
        send(fn, a, b, t);
        n = 1;
        while (!out_valid && n < 16) begin
            step();
            n++;
        end
        check({name, "_latency"}, n, DEPTH);
        check({name, "_result"}, out_result, exp_r);
        check({name, "_zero"}, out_zero, (exp_r == '0));
        check({name, "_tag"}, out_tag, t);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_out_valid"}, out_valid, 1'b0);
        check({name, "_out_result"}, out_result, '0);
        check({name, "_out_zero"}, out_zero, 1'b1);
        check({name, "_out_tag"}, out_tag, '0);
        check({name, "_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic flush_test(input int nheld);
        out_ready = 1'b0;
        for (int i = 0; i < nheld; i++) send(4'b0000, 32'(i), 32'd100, 5'(i + 8));
        step();
        step();
        load(4'b0110, 32'h0000_00F0, 32'h0000_000F, 5'd31);
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_clears", out_valid, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("flush_stays_empty", out_valid, 1'b0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sent;
        int n_acc;

        // reset
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        #1;
        check_reset_state("reset");

        // directed operations with known answers
        issue_and_check("add", 4'b0000, 32'd7, 32'hFFFF_FFF7, 5'd3, 32'hFFFF_FFFE);
        issue_and_check("sub", 4'b1000, 32'd5, 32'd5, 5'd4, 32'h0000_0000);
        issue_and_check("sra", 4'b1101, 32'h8000_0000, 32'h0000_0024, 5'd5, 32'hF800_0000);
        issue_and_check("srl", 4'b0101, 32'h8000_0000, 32'h0000_0024, 5'd6, 32'h0800_0000);
        issue_and_check("slt", 4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd1);
        issue_and_check("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'd0);
        issue_and_check("sll", 4'b0001, 32'd1, 32'h0000_003F, 5'd9, 32'h8000_0000);
        issue_and_check("badfn", 4'b1111, 32'h1234_5678, 32'd1, 5'd10, 32'd0);
        drain();

        // backpressure: 10 beats, consumer stalls cycles 4..9
        sent     = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (sent < 10 && !in_valid) begin
                rand_beat();
                in_valid = 1'b1;
            end
            out_ready = !(c >= 4 && c <= 9);
            step();
            if (accepted) begin
                sent++;
                in_valid = 1'b0;
            end
            if (sent == 10 && exp_q.size() == 0) break;
        end
        check("bp_sent", sent, 10);
        drain();

        // flush with a full pipe and with a pipe that can still accept
        flush_test(3);
        flush_test(2);

        // reset mid-stream, asserted together with flush
        out_ready = 1'b0;
        send(4'b0100, 32'hAAAA_0000, 32'h0000_5555, 5'd12);
        send(4'b0111, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd13);
        load(4'b0000, 32'd1, 32'd2, 5'd14);
        in_valid = 1'b1;
        RST      = 1'b1;
        flush    = 1'b1;
        step();
        RST      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check_reset_state("mid_reset");
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_reset_empty", out_valid, 1'b0);
        end

        // randomized traffic with random backpressure
        n_acc    = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 3000 && n_acc < 300; c++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                rand_beat();
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (accepted) begin
                n_acc++;
                in_valid = 1'b0;
            end
        end
        check("rand_accepted", n_acc, 300);
        drain();

`ifdef ALU_PERF_CNT_EN
        // 6 transfers and 4 stall cycles from a clean start
        RST = 1'b1;
        step();
        RST = 1'b0;
        exp_q.delete();
        out_ready = 1'b0;
        send(4'b0000, 32'd1, 32'd1, 5'd1);
        for (int i = 0; i < 16 && !out_valid; i++) step();
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(4'b0000, 32'(i), 32'd3, 5'(i + 2));
        drain();
        check("perf_ops", perf_ops, 32'd6);
        check("perf_stall", perf_stall, 32'd4);
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        check("perf_ops_rst", perf_ops, 32'd0);
        check("perf_stall_rst", perf_stall, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        timeout("watchdog");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
